// File: rtl/tpu_multi.sv
// rtl/tpu_multi.sv - multi-channel slot timer with byte register bus
module tpu_multi #(
    parameter int          N_CH      = 4,
    parameter int          TIMER_W   = 16,
    parameter logic [7:0]  BASE_ADDR = 8'h20
) (
    input  logic            SYS_CLK,
    input  logic            RST_N,
    input  logic [7:0]      addr,
    input  logic [7:0]      data_in,
    input  logic            we,
    output logic [7:0]      data_out,
    output logic [7:0]      cur_slot,
    output logic [N_CH-1:0] slot_gate,
    output logic [N_CH-1:0] slot_hit,
    output logic            irq
);

    logic [3:0]         ctrl;
    logic [TIMER_W-1:0] tmr;
    logic [TIMER_W-1:0] cnt;
    logic [7:0]         frame_len;
    logic               tflag;
    logic               chflag;
    logic [7:0]         ch_slot [N_CH];
    logic [2:0]         ch_cfg  [N_CH];
    logic [N_CH-1:0]    gate_d;
    logic [N_CH-1:0]    active;
    logic [N_CH-1:0]    hit_next;
    logic [N_CH-1:0]    ie;
    logic [7:0]         off;
    logic [15:0]        tmr_full;
    logic [7:0]         slot_last;
    logic [7:0]         rd_data;
    logic               srst;
    logic               tick;
    logic               w1c;

    always_comb begin
        off       = addr - BASE_ADDR;
        srst      = ctrl[0];
        tick      = !srst && (tmr != '0) && (cnt >= tmr);
        slot_last = frame_len - 8'd1;
        w1c       = we && (off == 8'd4);
        tmr_full  = '0;
        for (int b = 0; b < TIMER_W; b++) begin
            tmr_full[b] = tmr[b];
        end
        for (int k = 0; k < N_CH; k++) begin
            active[k] = ctrl[2] && ch_cfg[k][0] && (cur_slot == ch_slot[k]);
            ie[k]     = ch_cfg[k][2];
        end
        // Rising edge of the registered gate; drives hit, one-shot clear and CHFLAG together
        hit_next = srst ? '0 : (slot_gate & ~gate_d);
    end

    always_comb begin
        rd_data = '0;
        case (off)
            8'd0:    rd_data = {4'h0, ctrl};
            8'd1:    rd_data = tmr_full[7:0];
            8'd2:    rd_data = tmr_full[15:8];
            8'd3:    rd_data = frame_len;
            8'd4:    rd_data = {6'd0, chflag, tflag};
            8'd5:    rd_data = cur_slot;
            default: rd_data = '0;
        endcase
        for (int k = 0; k < N_CH; k++) begin
            if (off == 8'(8 + 2 * k)) rd_data = ch_slot[k];
            if (off == 8'(9 + 2 * k)) rd_data = {5'd0, ch_cfg[k]};
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RST_N) begin
            ctrl      <= 4'h1;
            tmr       <= '0;
            cnt       <= '0;
            frame_len <= '0;
            tflag     <= 1'b0;
            chflag    <= 1'b0;
            cur_slot  <= '0;
            slot_gate <= '0;
            gate_d    <= '0;
            slot_hit  <= '0;
            irq       <= 1'b0;
            data_out  <= '0;
            for (int k = 0; k < N_CH; k++) begin
                ch_slot[k] <= '0;
                ch_cfg[k]  <= '0;
            end
        end else begin
            if (we && off == 8'd0) ctrl      <= data_in[3:0];
            if (we && off == 8'd3) frame_len <= data_in;
            for (int b = 0; b < TIMER_W; b++) begin
                if (we && b < 8 && off == 8'd1)  tmr[b] <= data_in[b % 8];
                if (we && b >= 8 && off == 8'd2) tmr[b] <= data_in[b % 8];
            end
            // Software write is ordered after the one-shot clear so it takes priority
            for (int k = 0; k < N_CH; k++) begin
                if (hit_next[k] && ch_cfg[k][1]) ch_cfg[k][0] <= 1'b0;
                if (we && off == 8'(8 + 2 * k)) ch_slot[k] <= data_in;
                if (we && off == 8'(9 + 2 * k)) ch_cfg[k]  <= data_in[2:0];
            end

            if (srst) begin
                cnt       <= '0;
                cur_slot  <= '0;
                tflag     <= 1'b0;
                chflag    <= 1'b0;
                slot_gate <= '0;
                gate_d    <= '0;
                slot_hit  <= '0;
            end else begin
                cnt <= (tmr == '0 || tick) ? '0 : cnt + 1'b1;
                // >= so a frame length lowered below cur_slot wraps on the next tick
                if (tick) cur_slot <= (cur_slot >= slot_last) ? 8'd0 : cur_slot + 8'd1;
                tflag     <= tick | (tflag & ~(w1c & data_in[0]));
                chflag    <= (|(hit_next & ie)) | (chflag & ~(w1c & data_in[1]));
                slot_gate <= active;
                gate_d    <= slot_gate;
                slot_hit  <= hit_next;
            end

            irq      <= (tflag & ctrl[1]) | (chflag & ctrl[3]);
            data_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_tpu_multi.sv
// tb/tb_tpu_multi.sv - directed self-checking bench for tpu_multi
module tb_tpu_multi;

    logic       SYS_CLK;
    logic       RST_N;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic       we;
    logic [7:0] data_out;
    logic [7:0] cur_slot;
    logic [3:0] slot_gate;
    logic [3:0] slot_hit;
    logic       irq;

    int errors = 0;
    int checks = 0;

    tpu_multi #(.N_CH(4), .TIMER_W(16), .BASE_ADDR(8'h20)) dut (
        .SYS_CLK   (SYS_CLK),
        .RST_N     (RST_N),
        .addr      (addr),
        .data_in   (data_in),
        .we        (we),
        .data_out  (data_out),
        .cur_slot  (cur_slot),
        .slot_gate (slot_gate),
        .slot_hit  (slot_hit),
        .irq       (irq)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr    = a;
        data_in = d;
        we      = 1'b1;
        step();
        we      = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        addr = a;
        step();
        d = data_out;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) step();
        RST_N = 1'b1;
    endtask

    logic [7:0] v;
    int gate_cnt, gate_first, hit_cnt, hit_first, n, partial, hit2;
    logic [7:0] frozen;

    initial begin
        RST_N = 1'b1; addr = '0; data_in = '0; we = 1'b0;
        step();

        // Reset and defaults
        do_reset();
        chk("rst_irq", irq, 0);
        chk("rst_gate", slot_gate, 0);
        chk("rst_slot", cur_slot, 0);
        chk("rst_dout", data_out, 0);
        rd(8'h20, v); chk("rst_ctrl", v, 8'h01);
        rd(8'h21, v); chk("rst_tmr_lo", v, 8'h00);
        rd(8'h23, v); chk("rst_frame", v, 8'h00);
        rd(8'h24, v); chk("rst_status", v, 8'h00);
        rd(8'h29, v); chk("rst_cfg0", v, 8'h00);
        wr(8'h22, 8'hAB);
        rd(8'h22, v); chk("tmr_hi_rb", v, 8'hAB);
        wr(8'h30, 8'h5A);
        rd(8'h30, v); chk("unmapped", v, 8'h00);

        // Basic run
        do_reset();
        wr(8'h21, 8'd16); wr(8'h23, 8'd4); wr(8'h28, 8'd2); wr(8'h29, 8'h01);
        wr(8'h20, 8'h06);
        gate_cnt = 0; gate_first = 0; hit_cnt = 0; hit_first = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (i == 16) chk("basic_slot_i16", cur_slot, 0);
            if (i == 17) chk("basic_slot_i17", cur_slot, 1);
            if (i == 34) chk("basic_slot_i34", cur_slot, 2);
            if (i == 51) chk("basic_slot_i51", cur_slot, 3);
            if (i == 68) chk("basic_slot_i68", cur_slot, 0);
            if (slot_gate[0]) begin
                if (gate_cnt == 0) gate_first = i;
                gate_cnt++;
            end
            if (slot_hit[0]) begin
                if (hit_cnt == 0) hit_first = i;
                hit_cnt++;
            end
        end
        chk("basic_gate_len", gate_cnt, 17);
        chk("basic_gate_first", gate_first, 35);
        chk("basic_hit_cnt", hit_cnt, 1);
        chk("basic_hit_first", hit_first, 36);

        // Interrupt and W1C
        do_reset();
        wr(8'h21, 8'd10);
        wr(8'h20, 8'h02);
        repeat (11) step();
        chk("irq_before", irq, 0);
        step();
        chk("irq_after_tick", irq, 1);
        wr(8'h24, 8'h01);
        step();
        chk("irq_cleared", irq, 0);
        repeat (7) step();
        wr(8'h24, 8'h01);
        rd(8'h24, v); chk("w1c_vs_tick", v, 8'h01);
        chk("irq_w1c_vs_tick", irq, 1);

        // One-shot channel
        do_reset();
        wr(8'h21, 8'd4); wr(8'h23, 8'd4); wr(8'h2A, 8'd1); wr(8'h2B, 8'h07);
        wr(8'h20, 8'h0C);
        gate_cnt = 0; hit_cnt = 0; hit_first = 0; partial = 0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (slot_gate[1]) gate_cnt++;
            if (slot_hit[1]) begin
                if (hit_cnt == 0) hit_first = i;
                hit_cnt++;
            end
            if (slot_hit[0] || slot_hit[2] || slot_hit[3]) partial++;
        end
        chk("os_hit_cnt", hit_cnt, 1);
        chk("os_hit_first", hit_first, 7);
        chk("os_gate_len", gate_cnt, 2);
        chk("os_other_hits", partial, 0);
        chk("os_irq", irq, 1);
        rd(8'h2B, v); chk("os_cfg1", v, 8'h06);
        rd(8'h24, v); chk("os_status", v, 8'h03);

        // Mid-run changes
        do_reset();
        wr(8'h21, 8'd100); wr(8'h28, 8'd1); wr(8'h29, 8'h01);
        wr(8'h20, 8'h04);
        repeat (39) step();
        wr(8'h21, 8'd20);
        chk("mid_slot_pre", cur_slot, 0);
        step();
        chk("mid_tmr_lower_tick", cur_slot, 1);
        n = 0;
        while (cur_slot != 8'd3 && n < 100) begin step(); n++; end
        chk("mid_wait_slot3", cur_slot, 3);
        wr(8'h23, 8'd2);
        n = 0;
        while (cur_slot == 8'd3 && n < 40) begin step(); n++; end
        chk("mid_frame_wrap", cur_slot, 0);
        n = 0;
        while (cur_slot != 8'd1 && n < 40) begin step(); n++; end
        chk("mid_wait_slot1", cur_slot, 1);
        repeat (3) step();
        chk("mid_gate_on", slot_gate, 4'b0001);
        wr(8'h20, 8'h05);
        step();
        chk("srst_slot", cur_slot, 0);
        chk("srst_gate", slot_gate, 0);

        // Multi-channel, FRAME_LEN=0 (256 slots)
        do_reset();
        wr(8'h21, 8'd1);
        wr(8'h29, 8'h01); wr(8'h2B, 8'h01); wr(8'h2D, 8'h01); wr(8'h2F, 8'h01);
        wr(8'h20, 8'h04);
        hit_cnt = 0; hit_first = 0; hit2 = 0; partial = 0;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (slot_hit == 4'hF) begin
                if (hit_cnt == 0) hit_first = i;
                if (hit_cnt == 1) hit2 = i;
                hit_cnt++;
            end else if (slot_hit != 4'h0) begin
                partial++;
            end
        end
        chk("multi_hit_cnt", hit_cnt, 3);
        chk("multi_hit_first", hit_first, 2);
        chk("multi_hit_period", hit2 - hit_first, 512);
        chk("multi_partial", partial, 0);

        // TMR=0 freezes the slot counter
        wr(8'h21, 8'd0);
        frozen = cur_slot;
        chk("tmr0_slot_value", frozen, 38);
        partial = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (cur_slot != frozen) partial++;
        end
        chk("tmr0_frozen", partial, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
